// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the multi-device packet bus arbiter/router.
// The destination ID sits in the top ID_W bits of every packet.
package bus_arb_pkg;

  localparam int ID_W      = 8;
  localparam int PKT_MAX_W = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Callers zero-extend the packet to PKT_MAX_W and pass its real width.
  function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX_W-1:0] pkt,
                                               input int unsigned           pkt_w);
    logic [PKT_MAX_W-1:0] shifted;
    shifted = pkt >> (pkt_w - ID_W);
    return shifted[ID_W-1:0];
  endfunction

endpackage

// File: rtl/bus_arb_router_rr_arbiter.sv
// Combinational arbiter: round-robin from ptr_i+1 or fixed lowest-index priority.
// Zero latency; no state, grant is valid whenever any request is present.
module rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter  int drvrs = 5,
  localparam int IW    = (drvrs > 1) ? $clog2(drvrs) : 1
) (
  input  logic [drvrs-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  input  arb_mode_e        mode_i,
  output logic [drvrs-1:0] gnt_o,
  output logic [IW-1:0]    gnt_idx_o,
  output logic             any_req_o
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < drvrs; k++) begin
      if (mode_i == ARB_FIXED) begin
        cand = IW'(k);
      end else begin
        cand = IW'((int'(ptr_i) + 1 + k) % drvrs);
      end
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (found) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/bus_arb_router.sv
// Per-bus arbiter/router: IDLE -> POP -> PUSH, one packet every 3 cycles per bus.
// Pop one cycle after pndng is seen, push the cycle after; devices are never stalled.
module bus_arb_router
  import bus_arb_pkg::*;
#(
  parameter int         bits      = 1,
  parameter int         drvrs     = 5,
  parameter int         pckg_sz   = 16,
  parameter logic [7:0] broadcast = 8'h0F,
  parameter int         cnt_w     = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    arb_mode,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]              pop,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push,
  output logic [bits-1:0]                         busy,
  output logic [bits-1:0][cnt_w-1:0]              drop_cnt
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  for (genvar b = 0; b < bits; b++) begin : g_bus
    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, win_q;
    logic [drvrs-1:0]   win_oh_q;
    logic [pckg_sz-1:0] pkt_q;
    logic [cnt_w-1:0]   drop_q;

    logic [drvrs-1:0]   gnt;
    logic [IW-1:0]      gnt_idx;
    logic               any_req;
    logic [ID_W-1:0]    dest;
    logic               dest_bcast, dest_uni;
    logic [drvrs-1:0]   pop_b, push_b;
    logic [pckg_sz-1:0] dat_b;

    rr_arbiter #(.drvrs(drvrs)) u_arb (
      .req_i     (pndng[b]),
      .ptr_i     (ptr_q),
      .mode_i    (arb_mode_e'(arb_mode)),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_req_o (any_req)
    );

    assign dest       = get_dest(PKT_MAX_W'(pkt_q), pckg_sz);
    assign dest_bcast = (dest == broadcast);
    assign dest_uni   = !dest_bcast && ({24'd0, dest} < 32'(drvrs));

    always_comb begin
      state_d = state_q;
      case (state_q)
        IDLE:    if (any_req) state_d = POP;
        POP:     state_d = PUSH;
        PUSH:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= IDLE;
        ptr_q    <= IW'(drvrs - 1);
        win_q    <= '0;
        win_oh_q <= '0;
        pkt_q    <= '0;
        drop_q   <= '0;
      end else begin
        state_q <= state_d;
        if (state_q == IDLE && any_req) begin
          ptr_q    <= gnt_idx;
          win_q    <= gnt_idx;
          win_oh_q <= gnt;
        end
        if (state_q == POP) begin
          pkt_q <= D_pop[b][win_q];
        end
        // Invalid destinations are counted, never wrapped.
        if (state_q == PUSH && !dest_bcast && !dest_uni && drop_q != '1) begin
          drop_q <= drop_q + 1'b1;
        end
      end
    end

    always_comb begin
      pop_b  = '0;
      push_b = '0;
      dat_b  = '0;
      if (state_q == POP) begin
        pop_b = win_oh_q;
      end
      if (state_q == PUSH) begin
        dat_b = pkt_q;
        if (dest_bcast) begin
          push_b = ~win_oh_q;
        end else if (dest_uni) begin
          push_b[IW'(dest)] = 1'b1;
        end
      end
    end

    assign pop[b]      = pop_b;
    assign push[b]     = push_b;
    assign D_push[b]   = {drvrs{dat_b}};
    assign busy[b]     = (state_q != IDLE);
    assign drop_cnt[b] = drop_q;
  end

endmodule

// File: tb/tb_bus_arb_router.sv
// Bench: directed scenarios plus random traffic on two buses, checked every cycle
// against a transaction-level model of arbitration, routing and drop counting.
module tb_bus_arb_router;

  localparam int         BITS = 2;
  localparam int         DRV  = 5;
  localparam int         PW   = 16;
  localparam int         CW   = 8;
  localparam logic [7:0] BC   = 8'h0F;
  localparam int         QD   = 1024;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arb_mode = 1'b0;
  logic [BITS-1:0][DRV-1:0]         pndng = '0;
  logic [BITS-1:0][DRV-1:0][PW-1:0] D_pop = '0;
  logic [BITS-1:0][DRV-1:0]         pop, push;
  logic [BITS-1:0][DRV-1:0][PW-1:0] D_push;
  logic [BITS-1:0]                  busy;
  logic [BITS-1:0][CW-1:0]          drop_cnt;

  always #5 clk = ~clk;

  bus_arb_router #(
    .bits(BITS), .drvrs(DRV), .pckg_sz(PW), .broadcast(BC), .cnt_w(CW)
  ) dut (
    .clk(clk), .reset(reset), .arb_mode(arb_mode), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .busy(busy), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Device FIFOs
  logic [PW-1:0] fifo [BITS][DRV][QD];
  int hd [BITS][DRV];
  int tl [BITS][DRV];

  // Transaction-level model: phase 0 idle, 1 popping, 2 pushing
  int            m_phase [BITS];
  int            m_win   [BITS];
  int            m_ptr   [BITS];
  int            m_drop  [BITS];
  logic [PW-1:0] m_pkt   [BITS];

  logic [BITS-1:0][DRV-1:0]         last_pop, last_push;
  logic [BITS-1:0][DRV-1:0][PW-1:0] last_dpush;
  logic rand_en = 1'b0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic enq(input int b, input int d, input logic [PW-1:0] v);
    fifo[b][d][tl[b][d] % QD] = v;
    tl[b][d]++;
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [7:0] dst;
    case ($urandom_range(0, 3))
      0: dst = 8'($urandom_range(0, DRV - 1));
      1: dst = BC;
      2: begin
        dst = 8'($urandom_range(DRV, 255));
        if (dst == BC) dst = 8'h20;
      end
      default: dst = 8'($urandom_range(0, 255));
    endcase
    return {dst, 8'($urandom_range(0, 255))};
  endfunction

  function automatic int pick(input int mode, input int ptr, input logic [DRV-1:0] req);
    for (int k = 0; k < DRV; k++) begin
      int j;
      j = (mode != 0) ? k : (ptr + 1 + k) % DRV;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [DRV-1:0] route(input int dst, input int src);
    logic [DRV-1:0] v;
    v = '0;
    if (dst == int'(BC)) begin
      for (int i = 0; i < DRV; i++) if (i != src) v[i] = 1'b1;
    end else if (dst < DRV) begin
      v[dst] = 1'b1;
    end
    return v;
  endfunction

  function automatic int oh_idx(input logic [DRV-1:0] v);
    int idx;
    idx = -1;
    if ($countones(v) == 1)
      for (int i = 0; i < DRV; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  task automatic drive_inputs();
    for (int b = 0; b < BITS; b++)
      for (int d = 0; d < DRV; d++) begin
        pndng[b][d] = (tl[b][d] != hd[b][d]);
        D_pop[b][d] = pndng[b][d] ? fifo[b][d][hd[b][d] % QD] : '0;
      end
  endtask

  task automatic model_reset();
    for (int b = 0; b < BITS; b++) begin
      m_phase[b] = 0; m_win[b] = 0; m_ptr[b] = DRV - 1; m_drop[b] = 0; m_pkt[b] = '0;
      for (int d = 0; d < DRV; d++) hd[b][d] = tl[b][d];
    end
    last_pop = '0; last_push = '0; last_dpush = '0;
  endtask

  task automatic compare_all();
    for (int b = 0; b < BITS; b++) begin
      logic [DRV-1:0] ep, eu;
      logic [PW-1:0]  ed;
      ep = '0;
      if (m_phase[b] == 1) ep[m_win[b]] = 1'b1;
      eu = (m_phase[b] == 2) ? route(int'(m_pkt[b][PW-1 -: 8]), m_win[b]) : '0;
      ed = (m_phase[b] == 2) ? m_pkt[b] : '0;
      check($sformatf("pop[%0d]", b), 64'(pop[b]), 64'(ep));
      check($sformatf("push[%0d]", b), 64'(push[b]), 64'(eu));
      for (int d = 0; d < DRV; d++)
        check($sformatf("D_push[%0d][%0d]", b, d), 64'(D_push[b][d]), 64'(ed));
      check($sformatf("busy[%0d]", b), 64'(busy[b]), 64'(m_phase[b] != 0));
      check($sformatf("drop_cnt[%0d]", b), 64'(drop_cnt[b]), 64'(m_drop[b]));
    end
  endtask

  task automatic model_step();
    for (int b = 0; b < BITS; b++) begin
      case (m_phase[b])
        0: if (pndng[b] != '0) begin
          m_win[b] = pick(int'(arb_mode), m_ptr[b], pndng[b]);
          m_ptr[b] = m_win[b];
          m_phase[b] = 1;
        end
        1: begin
          m_pkt[b] = D_pop[b][m_win[b]];
          m_phase[b] = 2;
        end
        default: begin
          if (route(int'(m_pkt[b][PW-1 -: 8]), m_win[b]) == '0 && m_drop[b] < (1 << CW) - 1)
            m_drop[b]++;
          m_phase[b] = 0;
        end
      endcase
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    cyc++;
    for (int b = 0; b < BITS; b++)
      for (int d = 0; d < DRV; d++)
        if (last_pop[b][d] && hd[b][d] != tl[b][d]) hd[b][d]++;
    if (rand_en) begin
      if ($urandom_range(0, 19) == 0) arb_mode = ~arb_mode;
      for (int b = 0; b < BITS; b++)
        for (int d = 0; d < DRV; d++)
          if ($urandom_range(0, 9) == 0 && tl[b][d] - hd[b][d] < 40) enq(b, d, rand_pkt());
    end
    drive_inputs();
    @(negedge clk);
    compare_all();
    last_pop = pop;
    last_push = push;
    last_dpush = D_push;
    model_step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    drive_inputs();
    for (int b = 0; b < BITS; b++) begin
      check("rst_pop", 64'(pop[b]), 64'd0);
      check("rst_push", 64'(push[b]), 64'd0);
      check("rst_dpush0", 64'(D_push[b][0]), 64'd0);
      check("rst_busy", 64'(busy[b]), 64'd0);
      check("rst_drop", 64'(drop_cnt[b]), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < max_cycles) begin
      run_cycle();
      n++;
      done = 1'b1;
      for (int b = 0; b < BITS; b++) begin
        if (m_phase[b] != 0) done = 1'b0;
        for (int d = 0; d < DRV; d++) if (hd[b][d] != tl[b][d]) done = 1'b0;
      end
    end
    check("drain_done", 64'(done), 64'd1);
  endtask

  // Collects the first n grant indices on bus 0 and the cycles they occurred in.
  task automatic collect_grants(input int n, output int idx [6], output int at [6]);
    int got, lim;
    got = 0;
    lim = 0;
    for (int i = 0; i < 6; i++) begin idx[i] = -1; at[i] = -1; end
    while (got < n && lim < 60) begin
      run_cycle();
      lim++;
      if (last_pop[0] != '0) begin
        idx[got] = oh_idx(last_pop[0]);
        at[got] = cyc;
        got++;
      end
    end
    check("grant_count", 64'(got), 64'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int gi [6];
    int ga [6];
    int ord [6];
    for (int b = 0; b < BITS; b++)
      for (int d = 0; d < DRV; d++) begin hd[b][d] = 0; tl[b][d] = 0; end
    do_reset();

    // Unicast: device 1 -> device 3
    enq(0, 1, 16'h03AB);
    run_cycle();
    check("uni_idle_pop", 64'(last_pop[0]), 64'd0);
    run_cycle();
    check("uni_pop", 64'(last_pop[0]), 64'(5'b00010));
    run_cycle();
    check("uni_push", 64'(last_push[0]), 64'(5'b01000));
    check("uni_dpush0", 64'(last_dpush[0][0]), 64'h03AB);
    check("uni_dpush4", 64'(last_dpush[0][4]), 64'h03AB);
    run_cycle();
    check("uni_pop_after", 64'(last_pop[0]), 64'd0);
    check("uni_push_after", 64'(last_push[0]), 64'd0);

    // Broadcast from device 2
    enq(0, 2, 16'h0F55);
    repeat (3) run_cycle();
    check("bc_push", 64'(last_push[0]), 64'(5'b11011));
    check("bc_dpush", 64'(last_dpush[0][3]), 64'h0F55);
    run_cycle();

    // Invalid destination, then saturation
    enq(0, 0, 16'h07CC);
    repeat (3) run_cycle();
    check("inv_push", 64'(last_push[0]), 64'd0);
    check("inv_drop_before", 64'(drop_cnt[0]), 64'd0);
    run_cycle();
    check("inv_drop_after", 64'(drop_cnt[0]), 64'd1);
    for (int i = 0; i < 300; i++) enq(0, 0, {8'h07, 8'(i)});
    drain(1200);
    check("inv_drop_sat", 64'(drop_cnt[0]), 64'd255);

    // Asynchronous reset in the POP cycle
    enq(0, 3, 16'h0266);
    begin
      int n;
      n = 0;
      while (last_pop[0] == '0 && n < 10) begin run_cycle(); n++; end
    end
    check("mid_pop_seen", 64'(last_pop[0]), 64'(5'b01000));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pop", 64'(pop[0]), 64'd0);
    check("mid_rst_busy", 64'(busy[0]), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt[0]), 64'd0);
    do_reset();

    // Round-robin, all devices pending continuously
    for (int d = 0; d < DRV; d++)
      for (int k = 0; k < 3; k++) enq(0, d, {8'((d + 1) % DRV), 8'(16 * d + k)});
    collect_grants(6, gi, ga);
    ord = '{0, 1, 2, 3, 4, 0};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rr_order%0d", i), 64'(gi[i]), 64'(ord[i]));
      if (i > 0) check($sformatf("rr_gap%0d", i), 64'(ga[i] - ga[i-1]), 64'd3);
    end
    drain(200);

    // Fixed priority
    do_reset();
    arb_mode = 1'b1;
    for (int d = 0; d < DRV; d++)
      for (int k = 0; k < 2; k++) enq(0, d, {8'(d), 8'(k)});
    collect_grants(3, gi, ga);
    check("fix_g0", 64'(gi[0]), 64'd0);
    check("fix_g1", 64'(gi[1]), 64'd0);
    check("fix_g2", 64'(gi[2]), 64'd1);
    drain(200);
    arb_mode = 1'b0;

    // Two buses at once
    enq(0, 4, 16'h0011);
    enq(1, 0, 16'h0F22);
    repeat (3) run_cycle();
    check("mb_push0", 64'(last_push[0]), 64'(5'b00001));
    check("mb_push1", 64'(last_push[1]), 64'(5'b11110));
    check("mb_dpush0", 64'(last_dpush[0][0]), 64'h0011);
    check("mb_dpush1", 64'(last_dpush[1][1]), 64'h0F22);
    run_cycle();

    // Random traffic on both buses
    rand_en = 1'b1;
    repeat (3000) run_cycle();
    rand_en = 1'b0;
    drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
